// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - load/store arbiter for a single data-memory port (optional MEM_ARB_STARVE_GUARD_EN)
module mem_port_arbiter (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ld_req_valid,
    input  logic [31:0] ld_req_addr,
    input  logic [5:0]  ld_req_tag,
    output logic        ld_req_ready,
    input  logic        st_req_valid,
    input  logic [31:0] st_req_addr,
    input  logic [31:0] st_req_data,
    input  logic [1:0]  st_req_size,
    output logic        st_req_ready,
    input  logic        st_drain,
    input  logic        flush,
    output logic [31:0] data_address_2DM,
    output logic [31:0] data_write_2DM,
    output logic [1:0]  data_write_size_2DM,
    output logic        MemRead_2DM,
    output logic        MemWrite_2DM,
    input  logic [31:0] data_read_fDM,
    output logic        ld_resp_valid,
    output logic [5:0]  ld_resp_tag,
    output logic [31:0] ld_resp_data
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic [5:0]  tag_q, tag_d;
    logic        resp_valid_q, resp_valid_d;
    logic [5:0]  resp_tag_q, resp_tag_d;
    logic [31:0] resp_data_q, resp_data_d;

    logic        starve_force;
    logic        store_first;
    logic        ld_acc;
    logic        st_acc;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [2:0] starve_cnt_q, starve_cnt_d;

    assign starve_force = (starve_cnt_q == 3'd4);

    // Count back-to-back load grants while a store waits; cleared once the store gets in
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (st_acc || !st_req_valid) begin
            starve_cnt_d = 3'd0;
        end else if (ld_acc && !starve_force) begin
            starve_cnt_d = starve_cnt_q + 3'd1;
        end
    end

    // Starvation counter register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            starve_cnt_q <= 3'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    // A store jumps ahead of loads when the store buffer is draining or has been starved.
    // A squashed load cannot win, so a waiting store takes the port during flush.
    assign store_first  = st_req_valid & (st_drain | starve_force);
    assign ld_req_ready = RESET & ~flush & ~store_first;
    assign st_req_ready = RESET & ~(ld_req_valid & ld_req_ready);
    assign ld_acc       = ld_req_valid & ld_req_ready;
    assign st_acc       = st_req_valid & st_req_ready;

    // Next port state and payload for the coming cycle; response capture at the end of RD
    always_comb begin
        state_d      = IDLE;
        addr_d       = 32'd0;
        wdata_d      = 32'd0;
        size_d       = 2'd0;
        tag_d        = 6'd0;
        resp_valid_d = (state_q == RD) & ~flush;
        resp_tag_d   = resp_tag_q;
        resp_data_d  = resp_data_q;
        if (ld_acc) begin
            state_d = RD;
            addr_d  = {ld_req_addr[31:2], 2'b00};
            tag_d   = ld_req_tag;
        end else if (st_acc) begin
            state_d = WR;
            addr_d  = st_req_addr;
            wdata_d = st_req_data;
            size_d  = st_req_size;
        end
        if (state_q == RD) begin
            resp_tag_d  = tag_q;
            resp_data_d = data_read_fDM;
        end
    end

    // Port FSM and registered memory-side / response-side values
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            size_q       <= 2'd0;
            tag_q        <= 6'd0;
            resp_valid_q <= 1'b0;
            resp_tag_q   <= 6'd0;
            resp_data_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            tag_q        <= tag_d;
            resp_valid_q <= resp_valid_d;
            resp_tag_q   <= resp_tag_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign data_address_2DM    = addr_q;
    assign data_write_2DM      = wdata_q;
    assign data_write_size_2DM = size_q;
    assign MemRead_2DM         = (state_q == RD) & ~flush;
    assign MemWrite_2DM        = (state_q == WR);
    assign ld_resp_valid       = resp_valid_q & ~flush;
    assign ld_resp_tag         = resp_tag_q;
    assign ld_resp_data        = resp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ld_req_valid;
    logic [31:0] ld_req_addr;
    logic [5:0]  ld_req_tag;
    logic        ld_req_ready;
    logic        st_req_valid;
    logic [31:0] st_req_addr;
    logic [31:0] st_req_data;
    logic [1:0]  st_req_size;
    logic        st_req_ready;
    logic        st_drain;
    logic        flush;
    logic [31:0] data_address_2DM;
    logic [31:0] data_write_2DM;
    logic [1:0]  data_write_size_2DM;
    logic        MemRead_2DM;
    logic        MemWrite_2DM;
    logic [31:0] data_read_fDM;
    logic        ld_resp_valid;
    logic [5:0]  ld_resp_tag;
    logic [31:0] ld_resp_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign data_read_fDM = mem_word(data_address_2DM);

    mem_port_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_tag(ld_req_tag),
        .ld_req_ready(ld_req_ready),
        .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_data(st_req_data),
        .st_req_size(st_req_size), .st_req_ready(st_req_ready),
        .st_drain(st_drain), .flush(flush),
        .data_address_2DM(data_address_2DM), .data_write_2DM(data_write_2DM),
        .data_write_size_2DM(data_write_size_2DM), .MemRead_2DM(MemRead_2DM),
        .MemWrite_2DM(MemWrite_2DM), .data_read_fDM(data_read_fDM),
        .ld_resp_valid(ld_resp_valid), .ld_resp_tag(ld_resp_tag), .ld_resp_data(ld_resp_data)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ld_req_valid = 1'b0; ld_req_addr = 32'd0; ld_req_tag = 6'd0;
        st_req_valid = 1'b0; st_req_addr = 32'd0; st_req_data = 32'd0; st_req_size = 2'd0;
        st_drain = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        RESET = 1'b0;
        ld_req_valid = 1'b1; ld_req_addr = 32'h0000_4444; ld_req_tag = 6'h11;
        st_req_valid = 1'b1; st_req_addr = 32'h0000_5555;
        step(); step();
        n_checks++;
        if ({MemRead_2DM, MemWrite_2DM, ld_resp_valid, ld_req_ready, st_req_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {MemRead_2DM, MemWrite_2DM, ld_resp_valid, ld_req_ready, st_req_ready});
        end
        n_checks++;
        if ({data_address_2DM, data_write_2DM, data_write_size_2DM, ld_resp_tag, ld_resp_data} !== 104'd0) begin
            n_fail++;
            $display("FAIL reset_data: addr %h wdata %h size %h tag %h data %h expected all zero",
                     data_address_2DM, data_write_2DM, data_write_size_2DM, ld_resp_tag, ld_resp_data);
        end
        st_req_valid = 1'b0;
        RESET = 1'b1;
        step();
        n_checks++;
        if (MemRead_2DM !== 1'b1 || data_address_2DM !== 32'h0000_4444) begin
            n_fail++;
            $display("FAIL first_accept: MemRead %b addr %h expected 1 00004444", MemRead_2DM, data_address_2DM);
        end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_load();
        ld_req_valid = 1'b1; ld_req_addr = 32'h0000_1003; ld_req_tag = 6'h2A;
        #1;
        n_checks++;
        if (ld_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready: got %b expected 1", ld_req_ready);
        end
        step();
        clear_inputs();
        n_checks++;
        if (MemRead_2DM !== 1'b1 || MemWrite_2DM !== 1'b0 || data_address_2DM !== 32'h0000_1000 || data_write_size_2DM !== 2'd0) begin
            n_fail++;
            $display("FAIL load_rd: rd %b wr %b addr %h size %0d expected 1 0 00001000 0",
                     MemRead_2DM, MemWrite_2DM, data_address_2DM, data_write_size_2DM);
        end
        n_checks++;
        if (ld_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_early_resp: got %b expected 0", ld_resp_valid);
        end
        step();
        n_checks++;
        if (ld_resp_valid !== 1'b1 || ld_resp_tag !== 6'h2A || ld_resp_data !== 32'h1000_EFFF) begin
            n_fail++;
            $display("FAIL load_resp: valid %b tag %h data %h expected 1 2a 1000efff", ld_resp_valid, ld_resp_tag, ld_resp_data);
        end
        n_checks++;
        if (MemRead_2DM !== 1'b0 || data_address_2DM !== 32'd0) begin
            n_fail++;
            $display("FAIL load_idle: rd %b addr %h expected 0 00000000", MemRead_2DM, data_address_2DM);
        end
        step();
        n_checks++;
        if (ld_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_resp_once: got %b expected 0", ld_resp_valid);
        end
    endtask

    task automatic test_store();
        st_req_valid = 1'b1; st_req_addr = 32'h0000_2002; st_req_data = 32'h0000_BEEF; st_req_size = 2'd2;
        step();
        clear_inputs();
        n_checks++;
        if (MemWrite_2DM !== 1'b1 || MemRead_2DM !== 1'b0 || data_address_2DM !== 32'h0000_2002 ||
            data_write_2DM !== 32'h0000_BEEF || data_write_size_2DM !== 2'd2) begin
            n_fail++;
            $display("FAIL store_wr: wr %b rd %b addr %h data %h size %0d expected 1 0 00002002 0000beef 2",
                     MemWrite_2DM, MemRead_2DM, data_address_2DM, data_write_2DM, data_write_size_2DM);
        end
        step();
        n_checks++;
        if (ld_resp_valid !== 1'b0 || MemWrite_2DM !== 1'b0) begin
            n_fail++;
            $display("FAIL store_no_resp: resp %b wr %b expected 0 0", ld_resp_valid, MemWrite_2DM);
        end
    endtask

    task automatic test_arbitration();
        ld_req_valid = 1'b1; ld_req_addr = 32'h0000_0100; ld_req_tag = 6'h05;
        st_req_valid = 1'b1; st_req_addr = 32'h0000_0200; st_req_data = 32'h1234_5678; st_req_size = 2'd3;
        #1;
        n_checks++;
        if (ld_req_ready !== 1'b1 || st_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL arb_load_ready: ld %b st %b expected 1 0", ld_req_ready, st_req_ready);
        end
        step();
        n_checks++;
        if (MemRead_2DM !== 1'b1 || MemWrite_2DM !== 1'b0) begin
            n_fail++;
            $display("FAIL arb_load_win: rd %b wr %b expected 1 0", MemRead_2DM, MemWrite_2DM);
        end
        st_drain = 1'b1;
        #1;
        n_checks++;
        if (ld_req_ready !== 1'b0 || st_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL arb_drain_ready: ld %b st %b expected 0 1", ld_req_ready, st_req_ready);
        end
        step();
        clear_inputs();
        n_checks++;
        if (MemWrite_2DM !== 1'b1 || data_address_2DM !== 32'h0000_0200 || data_write_2DM !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL arb_drain_win: wr %b addr %h data %h expected 1 00000200 12345678",
                     MemWrite_2DM, data_address_2DM, data_write_2DM);
        end
        step(); step();
    endtask

    task automatic test_flush();
        ld_req_valid = 1'b1; ld_req_addr = 32'h0000_0808; ld_req_tag = 6'h3C;
        step();
        clear_inputs();
        flush = 1'b1;
        #1;
        n_checks++;
        if (MemRead_2DM !== 1'b0 || ld_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_rd: rd %b ld_ready %b expected 0 0", MemRead_2DM, ld_req_ready);
        end
        step();
        flush = 1'b0;
        #1;
        n_checks++;
        if (ld_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_resp_suppr: got %b expected 0", ld_resp_valid);
        end
        step();
        ld_req_valid = 1'b1; ld_req_addr = 32'h0000_0C00; ld_req_tag = 6'h07;
        step();
        clear_inputs();
        step();
        flush = 1'b1;
        #1;
        n_checks++;
        if (ld_resp_valid !== 1'b0 || ld_resp_tag !== 6'h07 || ld_resp_data !== 32'h0C00_F3FF) begin
            n_fail++;
            $display("FAIL flush_gate: valid %b tag %h data %h expected 0 07 0c00f3ff", ld_resp_valid, ld_resp_tag, ld_resp_data);
        end
        flush = 1'b0;
        #1;
        n_checks++;
        if (ld_resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ungate: got %b expected 1", ld_resp_valid);
        end
        step();
        flush = 1'b1;
        st_req_valid = 1'b1; st_req_addr = 32'h0000_0F01; st_req_data = 32'h0000_00AB; st_req_size = 2'd1;
        #1;
        n_checks++;
        if (st_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_st_ready: got %b expected 1", st_req_ready);
        end
        step();
        st_req_valid = 1'b0;
        #1;
        n_checks++;
        if (MemWrite_2DM !== 1'b1 || data_address_2DM !== 32'h0000_0F01 || data_write_2DM !== 32'h0000_00AB) begin
            n_fail++;
            $display("FAIL flush_store: wr %b addr %h data %h expected 1 00000f01 000000ab",
                     MemWrite_2DM, data_address_2DM, data_write_2DM);
        end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_starvation();
        logic exp_store;
        ld_req_valid = 1'b1; ld_req_addr = 32'h0000_0040; ld_req_tag = 6'h01;
        st_req_valid = 1'b1; st_req_addr = 32'h0000_3000; st_req_data = 32'h0000_0055; st_req_size = 2'd0;
        for (int i = 0; i < 10; i++) begin
            step();
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_store = ((i % 5) == 4);
`else
            exp_store = 1'b0;
`endif
            n_checks++;
            if (MemWrite_2DM !== exp_store || MemRead_2DM !== !exp_store) begin
                n_fail++;
                $display("FAIL starve_grant_%0d: wr %b rd %b expected %b %b", i, MemWrite_2DM, MemRead_2DM, exp_store, !exp_store);
            end
        end
        clear_inputs();
        step(); step(); step();
    endtask

    task automatic test_reset_mid();
        ld_req_valid = 1'b1; ld_req_addr = 32'h0000_ABCD; ld_req_tag = 6'h15;
        step();
        clear_inputs();
        RESET = 1'b0;
        #1;
        n_checks++;
        if (MemRead_2DM !== 1'b0 || data_address_2DM !== 32'd0 || ld_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: rd %b addr %h resp %b expected 0 00000000 0", MemRead_2DM, data_address_2DM, ld_resp_valid);
        end
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (ld_resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_resp_%0d: got %b expected 0", i, ld_resp_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_arbitration();
        test_flush();
        test_starvation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
